seq_normalizer: RTL and testbench
=================================

// Module: seq_normalizer
// PURPOSE
//  Iterative normalizer. It is the inverse companion of the 8-bit barrel shifter.
//  It takes a data word and shifts it one bit per cycle until the target end bit is 1.
//  It reports the normalized word and the shift amount, so the shifter can undo or
//  reapply the shift. It sits beside the shifter in the datapath (FP-style normalize / CLZ).
// PARAMETERS
//  WIDTH   8   data width; must be a power of 2, >= 2
//  CNT_W   3   shift-count width = log2(WIDTH)
// PORTS
//  clk    in   1        clock; all state changes on the rising edge
//  rst    in   1        synchronous, active-high reset
//  start  in   1        request; sampled only in IDLE
//  dir    in   1        0 = normalize toward MSB (left shift); 1 = toward LSB (right shift)
//  in     in   WIDTH    operand, captured when start is accepted
//  busy   out  1        high in SHIFT and DONE
//  done   out  1        1-cycle pulse; results are valid from this cycle onward
//  out    out  WIDTH    normalized word
//  shamt  out  CNT_W    number of single-bit shifts applied
//  zero   out  1        operand was all zeros
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, out=0, shamt=0, zero=0. Takes effect in any state, mid-op included.
//  States: IDLE, SHIFT, DONE (binary encoding).
//  IDLE:
//   - start=1, in!=0: capture in->work reg, dir->dir_q, cnt=0, zero=0 -> SHIFT.
//   - start=1, in==0: out=0, shamt=0, zero=1 -> DONE.
//   - start=0: stay in IDLE; outputs keep their last result.
//  SHIFT (target bit = work[WIDTH-1] if dir_q=0, else work[0]):
//   - target=1 or cnt==WIDTH-1: out=work, shamt=cnt -> DONE.
//   - otherwise: shift work by 1 toward the target, zero-filling the vacated end; cnt+=1.
//  DONE: done=1 for exactly one cycle -> IDLE. out/shamt/zero hold until the next accepted start.
//  Latency: start in cycle 0; k = required shifts (0..WIDTH-1); done is high in cycle k+2.
//   Zero operand: done is high in cycle 1.
//  start while busy (SHIFT or DONE): ignored, not queued. start in the DONE cycle is also ignored.
//  Invariants:
//   - in!=0: target bit of out is 1; cnt never wraps (saturation guard at WIDTH-1).
//   - Feeding the barrel shifter with (out, shamt, ~dir) reproduces the captured in exactly.
//  out/shamt/zero change only on an accepted start (zero cleared/set) or on the SHIFT->DONE
//  transition; never mid-shift.
// STRUCTURE
//  Shared include (seq_norm_defs.vh): state encodings S_IDLE/S_SHIFT/S_DONE, WIDTH/CNT_W defaults.
//  One sub-module: norm_step. Combinational single-bit shift by dir, zero fill, plus target-bit
//  extract. Everything else (FSM, counter, result regs) is in the top module.
// TESTING (WIDTH=8; cycle 0 = start cycle)
//  1. in=8'b0001_0110, dir=0 -> out=8'b1011_0000, shamt=3, zero=0; done in cycle 5 only.
//  2. in=8'h28, dir=1 -> out=8'h05, shamt=3; in=8'h01, dir=0 -> out=8'h80, shamt=7, done cycle 9.
//  3. in=8'h80, dir=0 -> out=8'h80, shamt=0, done cycle 2.
//     in=8'h00 -> zero=1, out=0, shamt=0, done cycle 1.
//  4. start pulsed in cycles 2-4 of test 1 -> ignored; results match test 1.
//     Next start in IDLE is accepted.
//  5. rst=1 in cycle 3 of in=8'h01 -> next cycle: IDLE, all outputs 0; no done pulse follows.
//  6. Random in/dir with a barrel-shifter reference model: shifter(out,shamt,~dir)==in;
//     latency == shamt+2 (1 when in==0).

Source files
------------

// File: rtl/seq_normalizer_pkg.sv
// Shared definitions for the iterative normalizer: FSM state encodings and default sizes.
package seq_normalizer_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_normalizer_norm_step.sv
// One normalization step: single-bit shift toward the target end with zero fill,
// plus the current target bit (MSB when shifting left, LSB when shifting right).
module norm_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] word_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] shifted_o,
   output logic             target_o
);

   always_comb begin
      if (dir_i) begin
         shifted_o = {1'b0, word_i[WIDTH-1:1]};
         target_o  = word_i[0];
      end else begin
         shifted_o = {word_i[WIDTH-2:0], 1'b0};
         target_o  = word_i[WIDTH-1];
      end
   end

endmodule

// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts the captured operand one bit per cycle until the
// target end bit is set, reporting the normalized word and the shift count.
module seq_normalizer
   import seq_normalizer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] shamt,
   output logic             zero
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] work_d;
   logic             dir_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             target;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] out_q;
   logic [CNT_W-1:0] shamt_q;
   logic             zero_q;

   norm_step #(.WIDTH(WIDTH)) u_step (
      .word_i    (work_q),
      .dir_i     (dir_q),
      .shifted_o (work_d),
      .target_o  (target)
   );

   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         shamt_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (in != '0) begin
                     work_q  <= in;
                     dir_q   <= dir;
                     cnt_q   <= '0;
                     zero_q  <= 1'b0;
                     state_q <= S_SHIFT;
                  end else begin
                     // All-zero operand has no target bit; finish straight away.
                     out_q   <= '0;
                     shamt_q <= '0;
                     zero_q  <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               if (target || cnt_q == CNT_MAX) begin
                  out_q   <= work_q;
                  shamt_q <= cnt_q;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  work_q <= work_d;
                  cnt_q  <= cnt_d;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign out   = out_q;
   assign shamt = shamt_q;
   assign zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed and random checks of seq_normalizer results, latency and reset behaviour.
module tb_seq_normalizer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_r = 1'b0;
   logic       dir_r = 1'b0;
   logic [7:0] in_r = 8'h00;
   logic       busy;
   logic       done;
   logic [7:0] out;
   logic [2:0] shamt;
   logic       zero;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   seq_normalizer #(.WIDTH(8), .CNT_W(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_r),
      .dir   (dir_r),
      .in    (in_r),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .shamt (shamt),
      .zero  (zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Start an operation at a negedge (cycle 0) and observe cycles 1..12.
   task automatic run_op(input string tag, input logic [7:0] a, input logic d,
                         input logic [7:0] eo, input logic [2:0] es, input logic ez,
                         input int elat, input bit inject);
      int first;
      int pulses;
      @(negedge clk);
      in_r = a; dir_r = d; start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      first = -1;
      pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 1) chk({tag, ".busy"}, 32'(busy), 32'd1);
         if (done) begin
            pulses++;
            if (first < 0) first = c;
         end
         if (inject && c >= 2 && c <= 4) begin
            start_r = 1'b1; in_r = 8'hFF; dir_r = ~d;
         end else begin
            start_r = 1'b0;
         end
         @(negedge clk);
      end
      chk({tag, ".lat"},   32'(first),  32'(elat));
      chk({tag, ".pulse"}, 32'(pulses), 32'd1);
      chk({tag, ".out"},   32'(out),    32'(eo));
      chk({tag, ".shamt"}, 32'(shamt),  32'(es));
      chk({tag, ".zero"},  32'(zero),   32'(ez));
      $display("op %s in=%02h dir=%0d out=%02h shamt=%0d zero=%0d lat=%0d",
               tag, a, d, out, shamt, zero, first);
   endtask

   initial begin
      logic [7:0] eo;
      logic [2:0] es;
      logic [7:0] a;
      logic       d;
      int         pulses;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst.busy",  32'(busy),  32'd0);
      chk("rst.done",  32'(done),  32'd0);
      chk("rst.out",   32'(out),   32'd0);
      chk("rst.shamt", 32'(shamt), 32'd0);
      chk("rst.zero",  32'(zero),  32'd0);

      run_op("t1",   8'h16, 1'b0, 8'hB0, 3'd3, 1'b0, 5, 1'b0);
      run_op("t2a",  8'h28, 1'b1, 8'h05, 3'd3, 1'b0, 5, 1'b0);
      run_op("t2b",  8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 9, 1'b0);
      run_op("t3a",  8'h80, 1'b0, 8'h80, 3'd0, 1'b0, 2, 1'b0);
      run_op("t3b",  8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1, 1'b0);
      run_op("t2c",  8'h80, 1'b1, 8'h01, 3'd7, 1'b0, 9, 1'b0);
      run_op("t4",   8'h16, 1'b0, 8'hB0, 3'd3, 1'b0, 5, 1'b1);
      run_op("t4b",  8'h40, 1'b1, 8'h01, 3'd6, 1'b0, 8, 1'b0);

      // Reset in cycle 3 of a long operation.
      @(negedge clk);
      in_r = 8'h01; dir_r = 1'b0; start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5.busy",  32'(busy),  32'd0);
      chk("t5.done",  32'(done),  32'd0);
      chk("t5.out",   32'(out),   32'd0);
      chk("t5.shamt", 32'(shamt), 32'd0);
      chk("t5.zero",  32'(zero),  32'd0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      chk("t5.nodone", 32'(pulses), 32'd0);
      $display("op t5 reset mid-shift busy=%0d out=%02h", busy, out);

      // Random operands against a count-leading/trailing-zeros model.
      for (int n = 0; n < 16; n++) begin
         a = 8'($urandom_range(0, 255));
         if (n == 0) a = 8'h00;
         d = 1'($urandom_range(0, 1));
         eo = a;
         es = 3'd0;
         if (a != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
               if ((d == 1'b0 && eo[7] == 1'b0) || (d == 1'b1 && eo[0] == 1'b0)) begin
                  eo = d ? (eo >> 1) : (eo << 1);
                  es = es + 3'd1;
               end
            end
         end
         run_op("rnd", a, d, eo, es, (a == 8'h00), (a == 8'h00) ? 1 : int'(es) + 2, 1'b0);
         chk("rnd.undo", 32'(d ? (out << shamt) : (out >> shamt)), 32'(a));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
